// File: rtl/core_input_sched.sv
// core_input_sched: round-robin scheduler that hands the realign/core-input path
// one 16-word block at a time, for one SHA256 thread at a time.
//
// Ports:
//   CLK, RST       clock, synchronous active-high reset
//   thread_req     per-thread block request (level)
//   thread_blk_op  per-thread block op, slice i belongs to thread i
//   src_rdy        realign has block data available
//   block_done     1-cycle pulse: 16th word of the current block written
//   thread_num     granted thread {core_num, seq_num}, held while busy
//   blk_op         op of the granted thread, held while busy
//   start          1-cycle pulse: begin transfer for thread_num
//   busy           high from grant through the ack cycle
//   thread_ack     one-hot 1-cycle pulse: block for that thread complete

`ifndef MSB
`define MSB(x) ($clog2((x)+1)-1)
`endif
`ifndef BLK_OP_MSB
`define BLK_OP_MSB 2
`endif

module core_input_sched #(
   parameter int N_CORES       = 3,
   parameter int N_CORES_MSB   = `MSB(N_CORES-1),
   parameter int N_THREADS     = 2*N_CORES,
   parameter int N_THREADS_MSB = `MSB(N_THREADS-1)
) (
   input  logic                                CLK,
   input  logic                                RST,
   input  logic [N_THREADS-1:0]                thread_req,
   input  logic [N_THREADS*(`BLK_OP_MSB+1)-1:0] thread_blk_op,
   input  logic                                src_rdy,
   input  logic                                block_done,
   output logic [N_THREADS_MSB:0]              thread_num,
   output logic [`BLK_OP_MSB:0]                blk_op,
   output logic                                start,
   output logic                                busy,
   output logic [N_THREADS-1:0]                thread_ack
);

   localparam int BW = `BLK_OP_MSB + 1;
   localparam int TW = N_THREADS_MSB + 1;
   localparam int SW = TW + 1;   // ptr + offset can reach 2*N_THREADS-2

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

   state_t               state;
   logic [TW-1:0]        ptr;
   logic                 holdoff;

   logic                 gnt_vld;
   logic [TW-1:0]        gnt_idx;
   logic [SW-1:0]        rr_sum;
   logic [N_CORES_MSB:0] gnt_core;
   logic                 gnt_seq;
   logic                 grant;

   // Priority search starting at ptr. N_THREADS is not a power of two, so the
   // wrap is an explicit compare-and-subtract rather than counter overflow.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      rr_sum  = '0;
      for (int k = 0; k < N_THREADS; k++) begin
         rr_sum = {1'b0, ptr} + SW'(k);
         if (rr_sum >= SW'(N_THREADS))
            rr_sum = rr_sum - SW'(N_THREADS);
         if (!gnt_vld && thread_req[rr_sum[TW-1:0]]) begin
            gnt_vld = 1'b1;
            gnt_idx = rr_sum[TW-1:0];
         end
      end
   end

   // Thread index is {core_num, seq_num}, two threads per core.
   assign gnt_core = gnt_idx[TW-1:1];
   assign gnt_seq  = gnt_idx[0];

   // holdoff gives requesters one IDLE cycle after ack to drop their request.
   assign grant = src_rdy && !holdoff && gnt_vld;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         ptr        <= '0;
         holdoff    <= 1'b0;
         thread_num <= '0;
         blk_op     <= '0;
         start      <= 1'b0;
         busy       <= 1'b0;
         thread_ack <= '0;
      end else begin
         start      <= 1'b0;
         thread_ack <= '0;
         case (state)
            IDLE: begin
               holdoff <= 1'b0;
               if (grant) begin
                  thread_num <= {gnt_core, gnt_seq};
                  blk_op     <= thread_blk_op[int'(gnt_idx)*BW +: BW];
                  busy       <= 1'b1;
                  start      <= 1'b1;
                  state      <= ISSUE;
               end
            end
            // block_done during ISSUE is deliberately not sampled.
            ISSUE: state <= WAIT;
            // Grant is committed: thread_req is not looked at here.
            WAIT: begin
               if (block_done) begin
                  thread_ack <= N_THREADS'(1) << thread_num;
                  state      <= ACK;
               end
            end
            ACK: begin
               busy    <= 1'b0;
               holdoff <= 1'b1;
               ptr     <= (thread_num == TW'(N_THREADS-1)) ? '0 : thread_num + TW'(1);
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_core_input_sched.sv
// Directed bench for core_input_sched: reset state, grant latency, round-robin
// order, post-ack holdoff, src_rdy gating, committed grant with spurious
// block_done, and reset abort.

`ifndef BLK_OP_MSB
`define BLK_OP_MSB 2
`endif

module tb_core_input_sched;

   localparam int NT = 6;
   localparam int BW = `BLK_OP_MSB + 1;

   logic              CLK = 1'b0;
   logic              RST = 1'b1;
   logic [NT-1:0]     thread_req = '0;
   logic [NT*BW-1:0]  thread_blk_op = '0;
   logic              src_rdy = 1'b0;
   logic              block_done = 1'b0;
   logic [2:0]        thread_num;
   logic [BW-1:0]     blk_op;
   logic              start;
   logic              busy;
   logic [NT-1:0]     thread_ack;

   int errs   = 0;
   int checks = 0;

   core_input_sched dut (
      .CLK          (CLK),
      .RST          (RST),
      .thread_req   (thread_req),
      .thread_blk_op(thread_blk_op),
      .src_rdy      (src_rdy),
      .block_done   (block_done),
      .thread_num   (thread_num),
      .blk_op       (blk_op),
      .start        (start),
      .busy         (busy),
      .thread_ack   (thread_ack)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_start(input int max, output int n);
      n = 0;
      while (!start && n < max) begin
         step();
         n++;
      end
      chk("start_seen", 32'(start), 32'd1);
   endtask

   // Serve one block: expect grant of th after lat cycles, raise block_done
   // dly cycles after the start cycle, then check ack and busy release.
   task automatic run_block(input int th, input int lat, input int dly);
      int n;
      wait_start(20, n);
      chk("gnt_latency", 32'(n), 32'(lat));
      chk("gnt_thread", 32'(thread_num), 32'(th));
      chk("gnt_op", 32'(blk_op), 32'(th + 1));
      chk("gnt_busy", 32'(busy), 32'd1);
      repeat (dly) begin
         step();
         chk("one_start", 32'(start), 32'd0);
         chk("wait_busy", 32'(busy), 32'd1);
         chk("wait_no_ack", 32'(thread_ack), 32'd0);
      end
      block_done = 1'b1;
      step();
      block_done = 1'b0;
      chk("ack_onehot", 32'(thread_ack), 32'd1 << th);
      chk("ack_busy", 32'(busy), 32'd1);
      step();
      chk("post_ack_clear", 32'(thread_ack), 32'd0);
      chk("post_ack_busy", 32'(busy), 32'd0);
      chk("holdoff_no_start", 32'(start), 32'd0);
   endtask

   task automatic do_reset();
      RST = 1'b1;
      step();
      step();
      chk("rst_thread_num", 32'(thread_num), 32'd0);
      chk("rst_blk_op", 32'(blk_op), 32'd0);
      chk("rst_start", 32'(start), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ack", 32'(thread_ack), 32'd0);
      RST = 1'b0;
   endtask

   initial begin
      int n;
      for (int i = 0; i < NT; i++)
         thread_blk_op[i*BW +: BW] = BW'(i + 1);

      // Single requester, long block.
      do_reset();
      thread_req = 6'b001000;
      src_rdy    = 1'b1;
      run_block(3, 1, 20);
      thread_req = '0;

      // All requesting: strict rotation from thread 0, holdoff adds a cycle.
      do_reset();
      thread_req = 6'b111111;
      for (int i = 0; i < 7; i++)
         run_block(i % NT, (i == 0) ? 1 : 2, 5);

      // Lone requester held across ack: no regrant in the holdoff cycle.
      thread_req = 6'b000001;
      run_block(0, 2, 3);
      thread_req = '0;

      // src_rdy low blocks arbitration.
      do_reset();
      src_rdy    = 1'b0;
      thread_req = 6'b100100;
      repeat (10) begin
         step();
         chk("nordy_start", 32'(start), 32'd0);
         chk("nordy_busy", 32'(busy), 32'd0);
      end
      src_rdy = 1'b1;
      run_block(2, 1, 4);
      run_block(5, 2, 4);
      thread_req = '0;

      // Committed grant: request dropped and block_done seen during ISSUE.
      step();
      thread_req = 6'b010000;
      wait_start(20, n);
      chk("c_latency", 32'(n), 32'd1);
      chk("c_thread", 32'(thread_num), 32'd4);
      chk("c_op", 32'(blk_op), 32'd5);
      thread_req = '0;
      block_done = 1'b1;
      step();
      block_done = 1'b0;
      chk("issue_done_ignored", 32'(thread_ack), 32'd0);
      chk("issue_done_busy", 32'(busy), 32'd1);
      repeat (3) begin
         step();
         chk("c_wait_no_ack", 32'(thread_ack), 32'd0);
         chk("c_wait_busy", 32'(busy), 32'd1);
      end
      block_done = 1'b1;
      step();
      block_done = 1'b0;
      chk("c_ack", 32'(thread_ack), 32'h10);
      step();
      chk("c_busy_fall", 32'(busy), 32'd0);
      block_done = 1'b1;
      step();
      block_done = 1'b0;
      chk("idle_done_ignored", 32'(thread_ack), 32'd0);

      // Reset in WAIT with thread 5 granted aborts without ack.
      thread_req = 6'b100000;
      wait_start(20, n);
      chk("r_latency", 32'(n), 32'd1);
      chk("r_thread", 32'(thread_num), 32'd5);
      repeat (3) step();
      RST        = 1'b1;
      thread_req = 6'b100001;
      step();
      chk("abort_thread_num", 32'(thread_num), 32'd0);
      chk("abort_blk_op", 32'(blk_op), 32'd0);
      chk("abort_start", 32'(start), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_ack", 32'(thread_ack), 32'd0);
      RST = 1'b0;
      run_block(0, 1, 3);
      thread_req = '0;

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errs, checks);
      $fatal(1);
   end

endmodule

// File: doc/core_input_sched.md
Name: core_input_sched

Overview:
- Round-robin scheduler that picks which SHA256 thread receives the next 16-word input block.
- Takes per-thread block requests and commits one thread at a time.
- Presents `thread_num`/`blk_op` plus a start pulse to the realign/core-input path, then waits for that path to report the 16th word written.
- Acknowledges the served thread and moves on; enforces exactly one block in flight.

Parameters:
- N_CORES, 3, number of SHA256 cores.
- N_CORES_MSB, `MSB(N_CORES-1), msb of core index.
- N_THREADS, 2*N_CORES, threads (2 per core; thread_num = {core_num, seq_num}).
- N_THREADS_MSB, `MSB(N_THREADS-1), msb of thread index.

Ports:
- CLK  in  1  clock; single clock domain.
- RST  in  1  synchronous, active-high reset.
- thread_req  in  N_THREADS  bit i: thread i requests an input block; level.
- thread_blk_op  in  N_THREADS*(`BLK_OP_MSB+1)  per-thread block op; slice i belongs to thread i.
- src_rdy  in  1  realign has block data available to send.
- block_done  in  1  1-cycle pulse: 16th word of current block written to core.
- thread_num  out  N_THREADS_MSB+1  granted thread, held while busy.
- blk_op  out  `BLK_OP_MSB+1  op of granted thread, held while busy.
- start  out  1  1-cycle pulse: begin transfer of block for thread_num.
- busy  out  1  high from grant until ack cycle inclusive.
- thread_ack  out  N_THREADS  one-hot 1-cycle pulse: block for that thread complete.

Behaviour:
- Reset: state=IDLE; thread_num=0, blk_op=0, start=0, busy=0, thread_ack=0; RR pointer=0 (thread 0 highest priority); holdoff=0. RST mid-operation aborts the block; no ack is issued.
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - Grant condition: src_rdy=1, holdoff=0 and thread_req!=0.
  - Selection: first requester at index >= ptr, wrapping modulo N_THREADS.
  - On grant: register thread_num and its thread_blk_op slice, set busy; go to ISSUE next cycle.
  - Otherwise stay in IDLE.
- ISSUE: start=1 for exactly this cycle; go to WAIT.
- WAIT:
  - Hold outputs until block_done=1, then go to ACK.
  - thread_req changes, including drop of the granted bit, are ignored; the grant is committed.
- ACK:
  - thread_ack[thread_num]=1 for exactly this cycle.
  - ptr <= thread_num+1, wrapping N_THREADS-1 -> 0.
  - holdoff <= 1; busy stays 1 this cycle, then 0.
  - Go to IDLE.
- holdoff blocks arbitration for the first IDLE cycle after ACK, so requesters have one cycle to drop req. It clears after that cycle.
- Latency: a request seen in IDLE at cycle t gives registered thread_num/blk_op and busy at t+1, with start=1 at t+1. block_done at cycle d gives ack at d+1; earliest next grant is at d+3.
- block_done in IDLE, ISSUE or ACK is ignored; no error state.
- block_done coinciding with the ISSUE cycle is ignored; only WAIT samples it.
- thread_num, blk_op and busy are registered. Combinational paths are allowed only from thread_req/src_rdy into the grant logic.
- Arithmetic:
  - ptr is N_THREADS_MSB+1 bits; wrap is explicit compare, not power-of-2 overflow, since N_THREADS=6.
  - Rotate/priority search covers all N_THREADS indices only.

Test Plan:
- Reset, then thread_req=6'b001000, src_rdy=1 -> next cycle thread_num=3, start pulse, busy=1. block_done 20 cycles later -> thread_ack=6'b001000 one cycle after, busy falls the cycle after that.
- thread_req=6'b111111 held, block_done 5 cycles after each start -> grant order 0,1,2,3,4,5,0; one start per block; never two blocks in flight.
- thread_req=6'b000001 held after ack -> no regrant in holdoff cycle; regrant of thread 0 at ack+2, i.e. the earliest next grant at d+3.
- thread_req=6'b100100, src_rdy=0 for 10 cycles -> no start, busy=0. src_rdy=1 -> thread 2 granted (ptr=0).
- Grant thread 4, drop thread_req[4] during WAIT, spurious block_done in ISSUE -> stays in WAIT until a block_done arrives in WAIT; ack still on bit 4.
- RST asserted in WAIT with thread 5 granted -> next cycle all outputs 0, no ack. With thread_req=6'b100001, thread 0 is granted first.
